// File: rtl/step_arbiter_ctrl_pkg.sv
// Shared definitions for the two-requester step machine arbiter/controller.
package step_arbiter_ctrl_pkg;
   localparam int   STEP_W_DEF = 4;
   localparam int   WRAP_W_DEF = 4;
   localparam logic DIR_UP     = 1'b1;
   localparam logic DIR_DN     = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } state_t;
endpackage

// File: rtl/step_arbiter_ctrl_rr_arb2.sv
// Two-way round-robin picker: rr_ptr breaks the tie when both request.
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic rr_ptr,
   output logic winner,
   output logic valid
);
   always_comb begin
      valid  = req0 | req1;
      winner = 1'b0;
      if (req0 && req1) winner = rr_ptr;
      else if (req1)    winner = 1'b1;
   end
endmodule

// File: rtl/step_arbiter_ctrl.sv
// Grants the shared step machine to one of two requesters, runs it for the
// latched step count, counts wrap-arounds and pulses done per requester.
module step_arbiter_ctrl
   import step_arbiter_ctrl_pkg::*;
#(
   parameter int STEP_W = STEP_W_DEF,
   parameter int WRAP_W = WRAP_W_DEF
) (
   input  logic              clck,
   input  logic              rst,
   input  logic              req0,
   input  logic              dir0,
   input  logic [STEP_W-1:0] steps0,
   input  logic              req1,
   input  logic              dir1,
   input  logic [STEP_W-1:0] steps1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic              busy,
   output logic              ctr_a,
   output logic              ctr_en,
   input  logic [2:0]        ctr_y,
   output logic [WRAP_W-1:0] wraps
);
   state_t            state, state_n;
   logic              owner, dir_q, rr_ptr;
   logic [STEP_W-1:0] cnt;
   logic              win, win_vld;
   logic              req_g, abort, pick, gnt_act, wrap_hit;

   rr_arb2 u_arb (
      .req0   (req0),
      .req1   (req1),
      .rr_ptr (rr_ptr),
      .winner (win),
      .valid  (win_vld)
   );

   always_comb begin
      req_g    = owner ? req1 : req0;
      abort    = ((state == LOAD) || (state == RUN)) && !req_g;
      pick     = (state == IDLE) && win_vld;
      gnt_act  = (state != IDLE) && !abort;
      wrap_hit = (ctr_a == DIR_UP) ? (ctr_y == 3'b111) : (ctr_y == 3'b000);
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: if (win_vld) state_n = LOAD;
         LOAD: begin
            if (abort)                state_n = IDLE;
            else if (cnt == '0)       state_n = DONE;
            else                      state_n = RUN;
         end
         RUN: begin
            if (abort)                    state_n = IDLE;
            else if (cnt == STEP_W'(1))   state_n = DONE;
         end
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clck or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   // Winner's request fields are latched once; later changes are ignored.
   always_ff @(posedge clck or negedge rst) begin
      if (!rst) begin
         owner  <= 1'b0;
         dir_q  <= 1'b0;
         cnt    <= '0;
         rr_ptr <= 1'b0;
      end else begin
         if (pick) begin
            owner <= win;
            dir_q <= win ? dir1 : dir0;
            cnt   <= win ? steps1 : steps0;
         end else if (state == RUN) begin
            cnt <= cnt - 1'b1;
         end
         if (abort || (state == DONE)) rr_ptr <= ~owner;
      end
   end

   // All outputs are registered from the current state, so a grant becomes
   // visible the cycle after LOAD and an abort clears them one edge later.
   always_ff @(posedge clck or negedge rst) begin
      if (!rst) begin
         gnt0   <= 1'b0;
         gnt1   <= 1'b0;
         done0  <= 1'b0;
         done1  <= 1'b0;
         busy   <= 1'b0;
         ctr_a  <= 1'b0;
         ctr_en <= 1'b0;
         wraps  <= '0;
      end else begin
         gnt0   <= gnt_act && !owner;
         gnt1   <= gnt_act && owner;
         done0  <= (state == DONE) && !owner;
         done1  <= (state == DONE) && owner;
         busy   <= (state_n != IDLE);
         ctr_a  <= gnt_act ? dir_q : DIR_DN;
         ctr_en <= (state == RUN) && !abort;
         if (pick)
            wraps <= '0;
         else if (ctr_en && wrap_hit && (wraps != {WRAP_W{1'b1}}))
            wraps <= wraps + 1'b1;
      end
   end
endmodule

// File: doc/step_arbiter_ctrl.md
Name: step_arbiter_ctrl

Overview:
- Controller and arbiter for the 3-bit bidirectional step state machine (direction input A, outputs Y2..Y0) used in the lab-6 designs.
- Two requesters share one step machine. Each requester asks for a run of N steps in a chosen direction. The block grants one requester at a time using round-robin, drives the machine's direction and enable for exactly N clocks, counts wrap-arounds, and signals completion.
- Sits between requester logic and the step machine.

Parameters:
- STEP_W, 4, width of the step-count request fields (max run = 2^STEP_W - 1 steps)
- WRAP_W, 4, width of the saturating wrap counter

Ports:
- clck  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req0  in  1  requester 0 run request; held high until done0, or dropped to abort
- dir0  in  1  requester 0 direction: 1 = up (A=1), 0 = down
- steps0  in  STEP_W  requester 0 step count
- req1, dir1, steps1  in  1/1/STEP_W  requester 1, same meaning
- gnt0, gnt1  out  1  grant to requester 0/1; one-hot or both zero
- done0, done1  out  1  one-cycle completion pulse per requester
- busy  out  1  high in every state except IDLE
- ctr_a  out  1  direction to step machine (its A input)
- ctr_en  out  1  step enable; machine advances one state per clock while high
- ctr_y  in  3  current step machine state {Y2,Y1,Y0}
- wraps  out  WRAP_W  wrap-arounds in the current/last run, saturating

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, gnt0=gnt1=0, done0=done1=0, busy=0, ctr_a=0, ctr_en=0, wraps=0, rr_ptr=0 (requester 0 has priority).
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - If any req is high, pick the winner. Priority goes to rr_ptr when both request.
  - Latch the winner's dir and steps into dir_q and cnt.
  - Clear wraps and go to LOAD.
- LOAD (1 cycle):
  - Winner's gnt goes high and ctr_a=dir_q. ctr_en stays 0.
  - If cnt==0, go to DONE. Otherwise go to RUN.
- RUN:
  - ctr_en=1 and cnt decrements each cycle. ctr_en is high for exactly the latched steps cycles.
  - Leave RUN the cycle after the cycle in which cnt reaches 1.
  - ctr_a stays constant for the whole grant.
- DONE (1 cycle):
  - done pulses for the granted requester. gnt stays high during this cycle.
  - rr_ptr points to the other requester. Next state is IDLE.
- Grant timing:
  - gnt drops when returning to IDLE.
  - Requester latency is request to gnt = 2 clocks; request to done = steps+3 clocks.
- Wrap counting:
  - In RUN, a wrap is counted when ctr_a=1 and ctr_y==3'b111, or when ctr_a=0 and ctr_y==3'b000.
  - Each wrap increments wraps, saturating at 2^WRAP_W-1.
  - wraps holds its value after DONE until the next LOAD clears it.
- Abort:
  - If the granted req drops in LOAD or RUN, ctr_en=0 and gnt=0 the next cycle, with no done pulse.
  - rr_ptr moves to the other requester and the FSM returns to IDLE.
- Request inputs:
  - The non-granted requester's req is ignored until IDLE.
  - steps and dir changes during a grant are ignored because values are latched.
- Simultaneous events:
  - Both req rise in the same IDLE cycle: rr_ptr wins.
  - A requester re-asserting on the same cycle its done pulses is seen in the next IDLE. If the other requester is waiting, the other requester wins.
- Outputs are registered. No combinational path from req to ctr_en.

Decomposition:
- Shared package holds:
  - FSM state encoding localparams (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3)
  - Default STEP_W and WRAP_W
  - Direction constants DIR_UP=1, DIR_DN=0
- One natural sub-module: rr_arb2, a 2-way round-robin picker (inputs req0, req1, rr_ptr; output winner, valid). It is purely combinational.
- Step counting and wrap detection stay in the top module.

Test Plan:
- Reset mid-RUN (rst=0 asynchronously while ctr_en=1) -> all outputs 0 immediately, without waiting for a clock edge. After release, the FSM is in IDLE and requester 0 has priority.
- req0=1, dir0=1, steps0=5, with the machine starting at y=0 -> gnt0 two clocks after req0 rises; ctr_en high for exactly 5 clocks; ctr_a=1 throughout; done0 pulses once at clock 8; wraps=0.
- req1=1, dir1=0, steps1=10, with the machine starting at y=3 -> ctr_en for 10 clocks; the 0→7 wrap is seen once; wraps=1; done1 pulses once.
- req0 and req1 both rise in the same cycle and both stay asserted -> requester 0 runs first, then requester 1, then requester 0; the grants alternate and gnt0/gnt1 are never high together.
- steps0=0 -> LOAD, then DONE; ctr_en never high; done0 pulses 3 clocks after the request.
- req0 drops on the third RUN cycle of an 8-step run -> ctr_en low the next cycle; no done0; requester 1 (pending) is granted next.
